// File: rtl/i2c_slave_regs_pkg.sv
// Shared types and defaults for the I2C-side register bank.
package i2c_slave_regs_pkg;

    localparam int AW_DEF = 4;
    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_PTR  = 1'b0,
        ST_DATA = 1'b1
    } state_e;

endpackage

// File: rtl/i2c_regs_mem.sv
// NREGS x 8 flop bank: I2C and host write ports with same-address arbitration,
// registered read mux and flattened contents.
module i2c_regs_mem
    import i2c_slave_regs_pkg::*;
#(
    parameter int                              AW      = AW_DEF,
    parameter logic [BYTE_W*(2**AW)-1:0]       RST_VAL = '0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               i2c_we_i,
    input  logic [AW-1:0]                      i2c_addr_i,
    input  logic [BYTE_W-1:0]                  i2c_dat_i,
    input  logic                               hw_we_i,
    input  logic [AW-1:0]                      hw_addr_i,
    input  logic [BYTE_W-1:0]                  hw_dat_i,
    input  logic [AW-1:0]                      rd_addr_i,
    output logic [BYTE_W-1:0]                  rdat_o,
    output logic                               hw_ack_o,
    output logic [BYTE_W*(2**AW)-1:0]          regs_o
);

    localparam int NREGS = 2**AW;

    logic [NREGS-1:0][BYTE_W-1:0] mem_q, mem_d;
    logic [BYTE_W-1:0]            rdat_q;
    logic                         hw_ack_q, hw_commit;

    // A same-cycle I2C write to the same byte wins; the host write is dropped.
    always_comb begin
        mem_d     = mem_q;
        hw_commit = hw_we_i && !(i2c_we_i && (hw_addr_i == i2c_addr_i));
        if (hw_commit) mem_d[hw_addr_i]  = hw_dat_i;
        if (i2c_we_i)  mem_d[i2c_addr_i] = i2c_dat_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= RST_VAL;
            rdat_q   <= RST_VAL[BYTE_W-1:0];
            hw_ack_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rdat_q   <= mem_q[rd_addr_i];
            hw_ack_q <= hw_commit;
        end
    end

    assign rdat_o   = rdat_q;
    assign hw_ack_o = hw_ack_q;
    assign regs_o   = mem_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// Register bank behind the I2C slave engine: pointer/state FSM, write notify,
// host update port.
module i2c_slave_regs
    import i2c_slave_regs_pkg::*;
#(
    parameter int                              AW      = AW_DEF,
    parameter logic [BYTE_W*(2**AW)-1:0]       RST_VAL = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               as_in,
    input  logic                               ws_in,
    input  logic [BYTE_W-1:0]                  wdat_in,
    input  logic                               rs_in,
    output logic [BYTE_W-1:0]                  rdat_out,
    input  logic                               hw_we,
    input  logic [AW-1:0]                      hw_addr,
    input  logic [BYTE_W-1:0]                  hw_dat,
    output logic                               hw_ack,
    output logic                               wr_stb_out,
    output logic [AW-1:0]                      wr_addr_out,
    output logic [BYTE_W*(2**AW)-1:0]          regs_out,
    output logic [AW-1:0]                      ptr_out
);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          i2c_we;
    logic          wr_stb_q;
    logic [AW-1:0] wr_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_PTR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // as_in masks everything; ws_in beats rs_in so a collision advances by one.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (as_in) begin
            state_d = ST_PTR;
        end else if (ws_in) begin
            if (state_q == ST_PTR) begin
                ptr_d   = wdat_in[AW-1:0];
                state_d = ST_DATA;
            end else begin
                ptr_d   = ptr_q + AW'(1);
            end
        end else if (rs_in) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_comb begin
        i2c_we = ws_in && !as_in && (state_q == ST_DATA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            wr_stb_q <= i2c_we;
            if (i2c_we) wr_addr_q <= ptr_q;
        end
    end

    i2c_regs_mem #(
        .AW      (AW),
        .RST_VAL (RST_VAL)
    ) u_mem (
        .clk_i      (clk),
        .rst_ni     (rst),
        .i2c_we_i   (i2c_we),
        .i2c_addr_i (ptr_q),
        .i2c_dat_i  (wdat_in),
        .hw_we_i    (hw_we),
        .hw_addr_i  (hw_addr),
        .hw_dat_i   (hw_dat),
        .rd_addr_i  (ptr_q),
        .rdat_o     (rdat_out),
        .hw_ack_o   (hw_ack),
        .regs_o     (regs_out)
    );

    assign wr_stb_out  = wr_stb_q;
    assign wr_addr_out = wr_addr_q;
    assign ptr_out     = ptr_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Table-driven bench for i2c_slave_regs with a scoreboard for write-notify and host-ack pulses.
module tb_i2c_slave_regs;

    localparam int AW = 4;
    localparam logic [127:0] RSTV = 128'h3C;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         as_in = 1'b0, ws_in = 1'b0, rs_in = 1'b0;
    logic [7:0]   wdat_in = '0;
    logic [7:0]   rdat_out;
    logic         hw_we = 1'b0;
    logic [AW-1:0] hw_addr = '0;
    logic [7:0]   hw_dat = '0;
    logic         hw_ack, wr_stb_out;
    logic [AW-1:0] wr_addr_out, ptr_out;
    logic [127:0] regs_out;

    always #5 clk = ~clk;

    i2c_slave_regs #(.AW(AW), .RST_VAL(RSTV)) dut (
        .clk(clk), .rst(rst), .as_in(as_in), .ws_in(ws_in), .wdat_in(wdat_in),
        .rs_in(rs_in), .rdat_out(rdat_out), .hw_we(hw_we), .hw_addr(hw_addr),
        .hw_dat(hw_dat), .hw_ack(hw_ack), .wr_stb_out(wr_stb_out),
        .wr_addr_out(wr_addr_out), .regs_out(regs_out), .ptr_out(ptr_out)
    );

    typedef struct {
        bit a, w, r;
        logic [7:0] wd;
        bit he;
        logic [3:0] ha;
        logic [7:0] hd;
        logic [3:0] ep;
        bit cr;
        logic [7:0] er;
        bit ew;
        logic [3:0] ewa;
        logic [7:0] ewd;
        bit ek;
    } vec_t;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } ev_t;

    vec_t tbl[$];
    ev_t  wq[$];
    ev_t  aq[$];
    ev_t  ew_e, ea_e;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(bit a, bit w, bit r, logic [7:0] wd,
                               bit he, logic [3:0] ha, logic [7:0] hd,
                               logic [3:0] ep, bit cr, logic [7:0] er,
                               bit ew, logic [3:0] ewa, logic [7:0] ewd, bit ek);
        vec_t t;
        t.a = a; t.w = w; t.r = r; t.wd = wd; t.he = he; t.ha = ha; t.hd = hd;
        t.ep = ep; t.cr = cr; t.er = er; t.ew = ew; t.ewa = ewa; t.ewd = ewd; t.ek = ek;
        return t;
    endfunction

    // Scoreboard: every notify / ack pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_stb_out) begin
                if (wq.size() == 0) chk("wr_stb_unexpected", 1, 0);
                else begin
                    ew_e = wq.pop_front();
                    chk("wr_addr_out", wr_addr_out, ew_e.a);
                    chk("wr_regs_byte", regs_out[8*ew_e.a +: 8], ew_e.d);
                end
            end
            if (hw_ack) begin
                if (aq.size() == 0) chk("hw_ack_unexpected", 1, 0);
                else begin
                    ea_e = aq.pop_front();
                    chk("hw_regs_byte", regs_out[8*ea_e.a +: 8], ea_e.d);
                end
            end
        end
    end

    task automatic apply(input vec_t t, input int idx);
        @(posedge clk); #1;
        as_in = t.a; ws_in = t.w; rs_in = t.r; wdat_in = t.wd;
        hw_we = t.he; hw_addr = t.ha; hw_dat = t.hd;
        if (t.ew) wq.push_back('{a: t.ewa, d: t.ewd});
        if (t.ek) aq.push_back('{a: t.ha, d: t.hd});
        @(posedge clk); #1;
        as_in = 0; ws_in = 0; rs_in = 0; hw_we = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_ptr", idx), ptr_out, t.ep);
        if (t.cr) chk($sformatf("v%0d_rdat", idx), rdat_out, t.er);
    endtask

    initial begin
        //                a  w  r  wd     he ha hd     ep cr er     ew ewa ewd   ek
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h03, 0, 0, 8'h00, 3,  1, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'hA5, 0, 0, 8'h00, 4,  0, 8'h00, 1, 3,  8'hA5, 0));
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 8'h00, 4,  0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h0F, 0, 0, 8'h00, 15, 0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h11, 0, 0, 8'h00, 0,  1, 8'h3C, 1, 15, 8'h11, 0));
        tbl.push_back(v(0, 1, 0, 8'h22, 0, 0, 8'h00, 1,  0, 8'h00, 1, 0,  8'h22, 0));
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h0F, 0, 0, 8'h00, 15, 1, 8'h11, 0, 0,  8'h00, 0));
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 8'h00, 15, 0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h30, 0, 0, 8'h00, 0,  1, 8'h22, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 0, 0, 8'h00, 1, 5, 8'h5A, 0,  0, 8'h00, 0, 0,  8'h00, 1));
        tbl.push_back(v(0, 0, 0, 8'h00, 1, 6, 8'h6B, 0,  0, 8'h00, 0, 0,  8'h00, 1));
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h05, 0, 0, 8'h00, 5,  1, 8'h5A, 0, 0,  8'h00, 0));
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 8'h00, 5,  1, 8'h5A, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 0, 1, 8'h00, 0, 0, 8'h00, 6,  1, 8'h6B, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 0, 1, 8'h00, 0, 0, 8'h00, 7,  1, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 8'h00, 7,  0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h02, 0, 0, 8'h00, 2,  0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h77, 1, 2, 8'h99, 3,  0, 8'h00, 1, 2,  8'h77, 0));
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 8'h00, 3,  0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h02, 0, 0, 8'h00, 2,  1, 8'h77, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h88, 1, 4, 8'h44, 3,  1, 8'hA5, 1, 2,  8'h88, 1));
        tbl.push_back(v(1, 1, 0, 8'hEE, 0, 0, 8'h00, 3,  1, 8'hA5, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h09, 0, 0, 8'h00, 9,  0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h12, 0, 0, 8'h00, 10, 0, 8'h00, 1, 9,  8'h12, 0));
        tbl.push_back(v(0, 1, 1, 8'h34, 0, 0, 8'h00, 11, 0, 8'h00, 1, 10, 8'h34, 0));
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 8'h00, 11, 0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 0, 1, 8'h00, 0, 0, 8'h00, 12, 0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h04, 0, 0, 8'h00, 4,  1, 8'h44, 0, 0,  8'h00, 0));
        tbl.push_back(v(1, 0, 1, 8'h00, 0, 0, 8'h00, 4,  0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h0F, 0, 0, 8'h00, 15, 0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 0, 1, 8'h00, 0, 0, 8'h00, 0,  1, 8'h22, 0, 0,  8'h00, 0));
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0,  8'h00, 0));
        tbl.push_back(v(0, 1, 0, 8'h06, 0, 0, 8'h00, 6,  0, 8'h00, 0, 0,  8'h00, 0));

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst_ptr", ptr_out, 0);
        chk("rst_rdat", rdat_out, 8'h3C);
        chk("rst_hw_ack", hw_ack, 0);
        chk("rst_wr_stb", wr_stb_out, 0);
        chk("rst_wr_addr", wr_addr_out, 0);
        chk("rst_regs", regs_out, RSTV);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        chk("wq_drained", wq.size(), 0);
        chk("aq_drained", aq.size(), 0);

        // Reset dropped mid-byte with strobes active: must clear without an edge
        @(posedge clk); #1;
        ws_in = 1; wdat_in = 8'h55; hw_we = 1; hw_addr = 4'd1; hw_dat = 8'hAA;
        rst = 1'b0;
        #1;
        chk("mid_rst_ptr", ptr_out, 0);
        chk("mid_rst_regs", regs_out, RSTV);
        chk("mid_rst_rdat", rdat_out, 8'h3C);
        chk("mid_rst_wr_addr", wr_addr_out, 0);
        chk("mid_rst_wr_stb", wr_stb_out, 0);
        chk("mid_rst_hw_ack", hw_ack, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("held_rst_regs", regs_out, RSTV);
        chk("held_rst_ptr", ptr_out, 0);
        ws_in = 0; hw_we = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_regs", regs_out, RSTV);
        chk("post_rst_ptr", ptr_out, 0);

        // First byte after reset must load the pointer, not store data
        apply(v(0, 1, 0, 8'h02, 0, 0, 8'h00, 2, 1, 8'h00, 0, 0, 8'h00, 0), 100);
        chk("post_rst_regs2", regs_out, RSTV);
        chk("wq_final", wq.size(), 0);
        chk("aq_final", aq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
